ysyx_24100005_ifu: RTL
======================

# ysyx_24100005_ifu

Instruction fetch unit for the ysyx_24100005 core. It owns the program counter, issues one word-aligned fetch at a time to instruction memory over a valid/ready request channel, and captures the response. It then presents the instruction with its PC to the decode/execute stage under a valid/ready handshake. A redirect input (branch/jump/trap target) squashes any in-flight fetch and restarts at the new PC.

## Interface

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; equals the current PC.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response valid; memory returns at most one response per accepted request.
- imem_resp_data  in  32  fetched instruction word.
- imem_resp_err  in  1  access fault for this response.
- redirect_valid  in  1  restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  instruction available to downstream.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- inst_err  out  1  fetch fault (misaligned PC or imem_resp_err).
- inst_ready  in  1  downstream consumes the instruction this cycle.

## Operation

- State registers: pc[31:0], state in {REQ, WAIT, OUT}, kill flag, and output registers inst, inst_pc, inst_err.
- imem_req_addr = pc.
- imem_req_valid = (state==REQ) && !redirect_valid && (pc[1:0]==0) && !rst.
- inst_valid = (state==OUT) && !redirect_valid.
- **REQ**
  - redirect_valid: pc <= redirect_pc, stay in REQ.
  - Else if pc[1:0]!=0: inst <= 32'h0000_0013 (nop), inst_pc <= pc, inst_err <= 1, go to OUT. No memory request is issued.
  - Else if imem_req_ready: go to WAIT.
  - imem_resp_valid seen in REQ is ignored.
- **WAIT**
  - imem_resp_valid && (kill || redirect_valid): discard the response, clear kill, go to REQ. On redirect_valid, pc <= redirect_pc.
  - imem_resp_valid otherwise: inst <= imem_resp_data, inst_pc <= pc, inst_err <= imem_resp_err, go to OUT.
  - redirect_valid without a response: pc <= redirect_pc, kill <= 1, stay in WAIT.
- **OUT**
  - redirect_valid: pc <= redirect_pc, go to REQ. The held instruction is dropped and counts as not consumed.
  - Else if inst_ready: pc <= pc + 4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to REQ.
  - Else hold; inst, inst_pc and inst_err stay stable.
- Only one outstanding request exists at any time.
- imem_req_addr changes only when imem_req_valid is 0 or after acceptance.

## Timing

- Reset (asynchronous, immediate): pc=RESET_PC, state=REQ, kill=0, inst=0, inst_pc=0, inst_err=0.
  - Outputs during reset: imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC.
- First request is valid in the first cycle after rst deasserts.
- Latency, request accepted at cycle N with response at cycle N+k (k≥1): inst_valid rises at cycle N+k+1.
- Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, OUT) with zero-wait memory and inst_ready held high.
- Redirect takes effect in the same cycle it is asserted. The new-PC request can be valid the following cycle if state was REQ/OUT, or after the stale response drains if state was WAIT.
- Reset asserted mid-WAIT: the pending memory response after reset must be ignored. The bench must not return it, because memory is reset alongside the IFU.
- Simultaneous redirect_valid and inst_ready in OUT: redirect wins and no handshake occurs.

## Test plan

- **Reset and sequential fetch.** Release rst; memory has ready=1 and returns data=addr^32'hA5A5_0000 one cycle after acceptance; inst_ready=1.
  - Requests go to 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - inst_valid pulses every 3rd cycle, with inst_pc matching each address and inst_err=0.
- **Backpressure.** Hold inst_ready=0 for 5 cycles in OUT.
  - inst/inst_pc stay stable and no new request is issued.
  - The next request to pc+4 follows the cycle after inst_ready=1.
- **Redirect in WAIT.** Request to 0x8000_0004 accepted; assert redirect to 0x8000_0100 before the response; memory responds 3 cycles later.
  - That response is dropped with no inst_valid.
  - The next request goes to 0x8000_0100.
- **Redirect in OUT with inst_ready=1 in the same cycle.**
  - No consumption occurs and pc becomes the redirect target.
  - The next inst_pc equals the redirect target.
- **Faults.** Redirect to 0x8000_0102: no request is issued; inst_valid with inst=32'h0000_0013, inst_err=1, inst_pc=0x8000_0102. Separately, a response with imem_resp_err=1 gives inst_err=1.
- **Async reset mid-WAIT.**
  - Outputs go to reset values without a clock edge.
  - After release, fetch restarts at 0x8000_0000.

Source files
------------

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and
// hands the instruction plus its PC downstream; redirects squash in-flight fetches.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        kill_reg, kill_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic        inst_err_reg, inst_err_next;
  logic        pc_misaligned;

  assign pc_misaligned  = (pc_reg[1:0] != 2'b00);
  assign imem_req_addr  = pc_reg;
  assign imem_req_valid = (state_reg == REQ) && !redirect_valid && !pc_misaligned && !rst;
  assign inst_valid     = (state_reg == OUT) && !redirect_valid;
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;
  assign inst_err       = inst_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= REQ;
      pc_reg       <= RESET_PC;
      kill_reg     <= 1'b0;
      inst_reg     <= 32'h0;
      inst_pc_reg  <= 32'h0;
      inst_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      kill_reg     <= kill_next;
      inst_reg     <= inst_next;
      inst_pc_reg  <= inst_pc_next;
      inst_err_reg <= inst_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    kill_next     = kill_reg;
    inst_next     = inst_reg;
    inst_pc_next  = inst_pc_reg;
    inst_err_next = inst_err_reg;
    unique case (state_reg)
      REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end else if (pc_misaligned) begin
          // Misaligned PC never reaches memory; deliver a faulting nop instead.
          inst_next     = NOP;
          inst_pc_next  = pc_reg;
          inst_err_next = 1'b1;
          state_next    = OUT;
        end else if (imem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (kill_reg || redirect_valid) begin
            kill_next  = 1'b0;
            state_next = REQ;
            if (redirect_valid) pc_next = redirect_pc;
          end else begin
            inst_next     = imem_resp_data;
            inst_pc_next  = pc_reg;
            inst_err_next = imem_resp_err;
            state_next    = OUT;
          end
        end else if (redirect_valid) begin
          // The stale response is still owed by memory; remember to drop it.
          pc_next   = redirect_pc;
          kill_next = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = REQ;
        end else if (inst_ready) begin
          pc_next    = pc_reg + 32'd4;
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

endmodule
